// File: rtl/sprite_update_sched_if.sv
// sprite_update_sched_if: host packet write port and sprite table update port
//   wr_valid/wr_data/wr_ready : host note-packet push handshake
//   upd_valid/upd_id/upd_x/upd_y/upd_n : sprite attribute table write strobe and fields
interface sprite_update_sched_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        upd_valid;
    logic [4:0]  upd_id;
    logic [9:0]  upd_x;
    logic [9:0]  upd_y;
    logic [5:0]  upd_n;
    modport master (output wr_valid, wr_data, input wr_ready, upd_valid, upd_id, upd_x, upd_y, upd_n);
    modport slave  (input wr_valid, wr_data, output wr_ready, upd_valid, upd_id, upd_x, upd_y, upd_n);
endinterface

// File: rtl/sprite_update_sched.sv
// sprite_update_sched: queues host sprite packets during active video and commits them in vertical blank
//   clk, reset     : system clock, asynchronous active-high reset
//   bus (slave)    : packet push handshake in, sprite table write strobe out
//   i_vcount       : current display row
//   i_clr_ovf      : synchronous clear of o_overflow (and o_drop_cnt)
//   o_frame_tick   : one-cycle pulse on entry to vertical blank
//   o_pending      : FIFO occupancy
//   o_overflow     : sticky dropped-packet flag
//   o_drop_cnt     : saturating dropped-packet count when SPRITE_SCHED_DROPCNT_EN is defined, else 0
module sprite_update_sched #(
    parameter int DEPTH   = 16,
    parameter int NSPR    = 32,
    parameter int VACTIVE = 480
) (
    input  logic                     clk,
    input  logic                     reset,
    sprite_update_sched_if.slave     bus,
    input  logic [9:0]               i_vcount,
    input  logic                     i_clr_ovf,
    output logic                     o_frame_tick,
    output logic [$clog2(DEPTH):0]   o_pending,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, HOLD} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0] r_count;
    logic        r_vblank, r_vblank_d;
    logic [4:0]  r_idx;
    logic        w_full, w_empty, w_push, w_drop, w_pop, w_rise, w_wr, w_clr_wr, w_tick;
    logic [31:0] w_head;

    // Full blocks a push even when a pop coincides, so occupancy never exceeds DEPTH.
    assign w_full       = r_count == (PW+1)'(DEPTH);
    assign w_empty      = r_count == '0;
    assign bus.wr_ready = ~w_full;
    assign w_push       = bus.wr_valid & ~w_full;
    assign w_drop       = bus.wr_valid & w_full;
    assign w_head       = r_mem[r_rptr];
    assign w_rise       = r_vblank & ~r_vblank_d;
    assign o_pending    = r_count;

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_wr     = 1'b0;
        w_clr_wr = 1'b0;
        w_tick   = 1'b0;
        case (r_state)
            IDLE: begin
                w_tick = w_rise;
                w_next = w_rise ? DRAIN : IDLE;
            end
            DRAIN: begin
                w_pop  = r_vblank & ~w_empty;
                w_wr   = w_pop & ~w_head[31];
                w_next = !r_vblank ? IDLE : w_empty ? HOLD : w_head[31] ? CLEAR : DRAIN;
            end
            // The burst always runs to completion, even if blank ends partway.
            CLEAR: begin
                w_clr_wr = 1'b1;
                w_next   = r_idx != 5'(NSPR-1) ? CLEAR : r_vblank ? DRAIN : IDLE;
            end
            HOLD: w_next = !r_vblank ? IDLE : w_empty ? HOLD : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vblank      <= 1'b0;
            r_vblank_d    <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_idx         <= '0;
            o_frame_tick  <= 1'b0;
            o_overflow    <= 1'b0;
            bus.upd_valid <= 1'b0;
            bus.upd_id    <= '0;
            bus.upd_x     <= '0;
            bus.upd_y     <= '0;
            bus.upd_n     <= '0;
        end else begin
            r_vblank      <= i_vcount >= 10'(VACTIVE);
            r_vblank_d    <= r_vblank;
            r_wptr        <= r_wptr + PW'(w_push);
            r_rptr        <= r_rptr + PW'(w_pop);
            r_count       <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            r_idx         <= w_clr_wr ? r_idx + 5'd1 : 5'd0;
            o_frame_tick  <= w_tick;
            o_overflow    <= w_drop | (o_overflow & ~i_clr_ovf);
            bus.upd_valid <= w_wr | w_clr_wr;
            if (w_wr) begin
                bus.upd_id <= w_head[30:26];
                bus.upd_n  <= w_head[25:20];
                bus.upd_y  <= w_head[19:10];
                bus.upd_x  <= w_head[9:0];
            end else if (w_clr_wr) begin
                bus.upd_id <= r_idx;
                bus.upd_n  <= '0;
                bus.upd_y  <= '0;
                bus.upd_x  <= '0;
            end
        end
    end

`ifdef SPRITE_SCHED_DROPCNT_EN
    logic [7:0] r_drop_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_drop_cnt <= '0;
        else       r_drop_cnt <= i_clr_ovf ? {7'd0, w_drop} : r_drop_cnt + 8'(w_drop && r_drop_cnt != 8'hFF);
    end
    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_sprite_update_sched.sv
// tb_sprite_update_sched: self-checking bench for sprite_update_sched
module tb_sprite_update_sched;
    localparam int DEPTH = 16;
    localparam int NSPR  = 32;
`ifdef SPRITE_SCHED_DROPCNT_EN
    localparam logic [7:0] DROP1 = 8'd1;
`else
    localparam logic [7:0] DROP1 = 8'd0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] vcount = '0;
    logic       clr_ovf = 1'b0;
    logic       frame_tick, overflow;
    logic [4:0] pending;
    logic [7:0] drop_cnt;
    sprite_update_sched_if bus();
    sprite_update_sched #(.DEPTH(DEPTH), .NSPR(NSPR), .VACTIVE(480)) dut (
        .clk(clk), .reset(reset), .bus(bus), .i_vcount(vcount), .i_clr_ovf(clr_ovf),
        .o_frame_tick(frame_tick), .o_pending(pending), .o_overflow(overflow), .o_drop_cnt(drop_cnt));
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot = 0;
    int mocc = 0;
    int run = 0;
    int last_run = 0;
    logic [31:0] exp_q [$];
    logic        movf = 1'b0;
    logic [7:0]  mdrop = '0;

    typedef struct {
        logic [9:0]  vc;
        logic        wv;
        logic [31:0] data;
        logic        uv;
        logic [4:0]  id;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [5:0]  n;
        logic        ft;
        logic [4:0]  pend;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: an accepted packet becomes its table writes, appended in FIFO order.
    task automatic model_push(input logic [31:0] d, output logic acc);
        acc = mocc < DEPTH;
        if (acc) begin
            mocc++;
            if (d[31]) for (int i = 0; i < NSPR; i++) exp_q.push_back({1'b0, 5'(i), 26'd0});
            else exp_q.push_back({1'b0, d[30:0]});
        end
    endtask

    task automatic push(input logic [31:0] d);
        logic acc;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        model_push(d, acc);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain();
        vcount = 10'd480;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_pending", 32'(pending), 32'd0);
        vcount = 10'd0;
        repeat (3) tick();
        mocc = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.upd_valid) begin
            run++;
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_write: got id=%0d x=%0d y=%0d n=%0d expected no write",
                         bus.upd_id, bus.upd_x, bus.upd_y, bus.upd_n);
            end else chk("write_order", {1'b0, bus.upd_id, bus.upd_n, bus.upd_y, bus.upd_x}, exp_q.pop_front());
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic acc, wv, clr, drop;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        p = {1'b0, 5'd3, 6'd4, 10'd50, 10'd100};
        tbl[0] = '{10'd200, 1'b1, p,     1'b0, 5'd0, 10'd0,   10'd0,  6'd0, 1'b0, 5'd1};
        tbl[1] = '{10'd200, 1'b0, 32'd0, 1'b0, 5'd0, 10'd0,   10'd0,  6'd0, 1'b0, 5'd1};
        tbl[2] = '{10'd480, 1'b0, 32'd0, 1'b0, 5'd0, 10'd0,   10'd0,  6'd0, 1'b0, 5'd1};
        tbl[3] = '{10'd480, 1'b0, 32'd0, 1'b0, 5'd0, 10'd0,   10'd0,  6'd0, 1'b1, 5'd1};
        tbl[4] = '{10'd480, 1'b0, 32'd0, 1'b1, 5'd3, 10'd100, 10'd50, 6'd4, 1'b0, 5'd0};
        tbl[5] = '{10'd480, 1'b0, 32'd0, 1'b0, 5'd3, 10'd100, 10'd50, 6'd4, 1'b0, 5'd0};
        tbl[6] = '{10'd0,   1'b0, 32'd0, 1'b0, 5'd3, 10'd100, 10'd50, 6'd4, 1'b0, 5'd0};
        tbl[7] = '{10'd0,   1'b0, 32'd0, 1'b0, 5'd3, 10'd100, 10'd50, 6'd4, 1'b0, 5'd0};
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rst_upd_fields", {1'b0, bus.upd_id, bus.upd_n, bus.upd_y, bus.upd_x}, 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

        // Deferred commit, cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            vcount = tbl[i].vc;
            bus.wr_valid = tbl[i].wv;
            bus.wr_data = tbl[i].data;
            if (tbl[i].wv) model_push(tbl[i].data, acc);
            tick();
            chk($sformatf("tbl%0d_upd_valid", i), 32'(bus.upd_valid), 32'(tbl[i].uv));
            chk($sformatf("tbl%0d_fields", i), {1'b0, bus.upd_id, bus.upd_n, bus.upd_y, bus.upd_x},
                {1'b0, tbl[i].id, tbl[i].n, tbl[i].y, tbl[i].x});
            chk($sformatf("tbl%0d_frame_tick", i), 32'(frame_tick), 32'(tbl[i].ft));
            chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
        end
        bus.wr_valid = 1'b0;
        mocc = 0;

        // Overflow: 17 pushes into a 16-entry FIFO.
        for (int k = 0; k < 17; k++) begin
            push({1'b0, 5'(k), 6'(k + 1), 10'(k * 3), 10'(k * 7)});
            chk($sformatf("ovf_pending%0d", k), 32'(pending), 32'(k < 16 ? k + 1 : 16));
            chk($sformatf("ovf_wr_ready%0d", k), 32'(bus.wr_ready), 32'(k + 1 < 16));
        end
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'(DROP1));
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf_flag", 32'(overflow), 32'd0);
        chk("clr_ovf_drop_cnt", 32'(drop_cnt), 32'd0);

        // Push at occupancy DEPTH while DRAIN pops: still dropped.
        vcount = 10'd480;
        for (int i = 0; i < 8 && !frame_tick; i++) tick();
        chk("full_frame_tick", 32'(frame_tick), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_data = 32'h7FFF_FFFF;
        tick();
        bus.wr_valid = 1'b0;
        chk("full_pp_pending", 32'(pending), 32'd15);
        chk("full_pp_overflow", 32'(overflow), 32'd1);
        drain();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Clear burst followed by a normal packet: 33 consecutive writes.
        last_run = 0;
        push(32'hFFFF_FFFF);
        push({1'b0, 5'd7, 6'd2, 10'd22, 10'd11});
        drain();
        chk("clear_run_len", 32'(last_run), 32'd33);

        // Blank ends after 3 cycles: two packets commit, three wait for the next frame.
        for (int k = 0; k < 5; k++) push({1'b0, 5'(k + 20), 6'(k), 10'(k + 1), 10'(k + 2)});
        vcount = 10'd480;
        repeat (3) tick();
        vcount = 10'd0;
        repeat (4) tick();
        chk("midq_pending", 32'(pending), 32'd3);
        chk("midq_left", 32'(exp_q.size()), 32'd3);
        drain();

        // Asynchronous reset in the middle of a clear burst.
        push(32'h8000_0000);
        vcount = 10'd480;
        for (int i = 0; i < 100 && !(bus.upd_valid && bus.upd_id == 5'd10); i++) tick();
        chk("rstclr_at_idx10", 32'(bus.upd_id), 32'd10);
        #1 reset = 1'b1;
        #1;
        chk("rstclr_upd_valid", 32'(bus.upd_valid), 32'd0);
        chk("rstclr_pending", 32'(pending), 32'd0);
        exp_q.delete();
        mocc = 0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (20) tick();
        chk("rstclr_after_pending", 32'(pending), 32'd0);
        vcount = 10'd0;
        repeat (3) tick();
        movf = 1'b0;
        mdrop = '0;

        // Random pushes in active video against the model, then a full drain.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 40; c++) begin
                wv = 1'($urandom_range(0, 1));
                p = $urandom;
                if ($urandom_range(0, 7) != 0) p[31] = 1'b0;
                clr = $urandom_range(0, 9) == 0;
                bus.wr_valid = wv;
                bus.wr_data = p;
                clr_ovf = clr;
                acc = 1'b0;
                if (wv) model_push(p, acc);
                drop = wv & ~acc;
                movf = drop | (movf & ~clr);
`ifdef SPRITE_SCHED_DROPCNT_EN
                mdrop = clr ? 8'(drop) : (drop && mdrop != 8'hFF) ? mdrop + 8'd1 : mdrop;
`endif
                tick();
                chk("rnd_pending", 32'(pending), 32'(mocc));
                chk("rnd_wr_ready", 32'(bus.wr_ready), 32'(mocc < DEPTH));
                chk("rnd_overflow", 32'(overflow), 32'(movf));
                chk("rnd_drop_cnt", 32'(drop_cnt), 32'(mdrop));
            end
            bus.wr_valid = 1'b0;
            clr_ovf = 1'b0;
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/sprite_update_sched.md
# sprite_update_sched

Frame-synchronous scheduler for the sprite attribute table of the VGA sprite engine. Host note-packet writes arrive from the Avalon slave and are queued in a FIFO during active video. They are committed to the sprite table only during vertical blanking, so the scanline compositor never reads a half-updated note set. It also sequences a bulk "clear all sprites" command as a burst of table writes.

## Interface
Parameters:
- DEPTH, 16: FIFO entries (power of two).
- NSPR, 32: sprite table entries; also the clear-burst length.
- VACTIVE, 480: first vcount value that is vertical blank.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  host packet strobe (decoded chipselect && write && sprite address).
- wr_data  in  32  packet fields:
  - [31] clear-all
  - [30:26] id
  - [25:20] n
  - [19:10] y
  - [9:0] x
- wr_ready  out  1  FIFO not full; combinational from the occupancy register.
- vcount  in  10  current display row from the VGA counters.
- upd_valid  out  1  sprite table write strobe (registered).
- upd_id  out  5  table index.
- upd_x  out  10  x coordinate.
- upd_y  out  10  y coordinate.
- upd_n  out  6  sprite count/enable; 0 disables the entry.
- frame_tick  out  1  one-cycle pulse on entry to vertical blank.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set when a packet is dropped.
- clr_ovf  in  1  synchronous clear of overflow.
- drop_cnt  out  8  dropped-packet count (see Configuration).

## Operation
- Push: wr_valid && wr_ready writes wr_data at the tail.
- A wr_valid while full drops the packet and sets overflow.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- The FIFO is not full when a pop and a push coincide at occupancy DEPTH-1.
- A push at occupancy DEPTH is rejected even if a pop occurs in the same cycle.
- Blank flag: vblank_r <= (vcount >= VACTIVE), registered.
- States:
  - IDLE: active video; accept pushes only. On the vblank_r rise: pulse frame_tick and go to DRAIN.
  - DRAIN: pop one entry per cycle while the FIFO is non-empty.
    - A normal entry produces one upd_* write.
    - An entry with bit 31 set produces no direct write and goes to CLEAR.
    - FIFO empty → HOLD.
    - vblank_r falls → IDLE; unpopped entries are retained for the next frame.
  - CLEAR: a 5-bit index runs 0..NSPR-1, one write per cycle with upd_x=upd_y=upd_n=0.
    - After index NSPR-1: return to DRAIN, or to IDLE if vblank_r has fallen.
    - CLEAR always completes its burst, even across the end of blank.
  - HOLD: blank with the FIFO empty.
    - A new push → DRAIN.
    - vblank_r fall → IDLE.
- upd_* fields not being written hold their last value; upd_valid is 0 outside writes.
- clr_ovf and a simultaneous drop in the same cycle: overflow stays set.

## Timing
- Reset values:
  - state IDLE; FIFO empty; pending 0; wr_ready 1.
  - upd_valid 0; upd_id/x/y/n 0.
  - frame_tick 0; overflow 0; drop_cnt 0.
- Reset mid-DRAIN or mid-CLEAR aborts immediately; no upd_valid after reset is asserted; queued packets are lost.
- frame_tick asserts 2 cycles after the first clock with vcount == VACTIVE (vcount sampled into vblank_r, then edge detected).
- First upd_valid appears 1 cycle after frame_tick.
- FIFO latency: a packet pushed in cycle t can appear on upd_* no earlier than t+2 (push, then pop-register).
- DRAIN throughput: one write per cycle. Worst case is DEPTH clear commands = DEPTH×(NSPR+1) cycles, well under one blank period (45 lines × 1600 cycles).
- Write ordering: upd_* writes occur in FIFO order; a later packet for the same id overwrites the earlier one.

## Configuration
- SPRITE_SCHED_DROPCNT_EN defined: drop_cnt is an 8-bit counter incremented on every dropped packet.
  - It saturates at 255.
  - It is cleared by reset or clr_ovf.
- SPRITE_SCHED_DROPCNT_EN undefined: drop_cnt is tied to 0 and no counter logic is synthesized. overflow behaviour is unchanged.

## Test plan
- Deferred commit: push x=100, y=50, n=4, id=3 at vcount=200.
  - No upd_valid before blank.
  - At vcount=480: frame_tick, then next cycle upd_valid with id 3, x 100, y 50, n 4.
- Overflow: push 17 packets during active video with DEPTH=16.
  - wr_ready drops after the 16th; overflow=1; drop_cnt=1 with the macro, 0 without.
  - During blank, exactly 16 writes drain in order.
- Clear burst: queue a packet with bit 31 set, then id=7 with n=2.
  - In blank: 32 writes with id 0..31 and n=0, then one write id 7 with n=2; total 33 consecutive upd_valid.
- Blank ends mid-queue: push packets while blank is held for 3 cycles, and force vcount to 0.
  - DRAIN stops; pending equals the remainder.
  - The remainder drains at the next frame_tick.
- Simultaneous push/pop at full: at occupancy 16 in DRAIN, assert wr_valid.
  - The packet is dropped, overflow=1, pending=15 next cycle.
- Async reset mid-CLEAR: assert reset at clear index 10.
  - upd_valid=0 immediately; pending=0; state IDLE.
  - No writes occur until the next queued packet and the next blank.
